// File: rtl/fib_inv.sv
// Inverse Fibonacci index finder: for a latched value, returns the largest
// n with F(n) <= value and whether the value is exactly F(n).
module fib_inv #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_stb,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_busy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_n,
    output logic             o_exact
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_RUN  = 1'b1;

    logic             state;
    logic [WIDTH-1:0] val;
    logic [WIDTH-1:0] k;
    logic [WIDTH:0]   a;
    logic [WIDTH:0]   b;
    logic [WIDTH:0]   val_ext;

    assign val_ext = {1'b0, val};
    assign o_busy  = (state == S_RUN);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= S_IDLE;
            val     <= '0;
            k       <= '0;
            a       <= '0;
            b       <= '0;
            o_valid <= 1'b0;
            o_n     <= '0;
            o_exact <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_stb) begin
                        val   <= i_value;
                        a     <= '0;
                        b     <= {{WIDTH{1'b0}}, 1'b1};
                        k     <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // b = F(k+1) passing val means k is the answer
                    if (b > val_ext) begin
                        o_n     <= k;
                        o_exact <= (a == val_ext);
                        o_valid <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        a <= b;
                        b <= a + b;
                        k <= k + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_inv.sv
// Scoreboard bench for fib_inv: driver pushes reference results,
// monitor pops and compares on every o_valid pulse.
module tb_fib_inv;

    localparam int WIDTH = 8;

    typedef struct {
        int n;
        int exact;
        int blen;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             stb;
    logic [WIDTH-1:0] val;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] n;
    logic             exact;

    int   tests = 0;
    int   fails = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    fib_inv #(.WIDTH(WIDTH)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_stb   (stb),
        .i_value (val),
        .o_busy  (busy),
        .o_valid (valid),
        .o_n     (n),
        .o_exact (exact)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: largest index of a Fibonacci table entry not above v
    function automatic exp_t mk(input int v);
        int   f[0:15];
        exp_t e;
        f[0] = 0;
        f[1] = 1;
        for (int i = 2; i < 16; i++) f[i] = f[i-1] + f[i-2];
        e.n = 0;
        for (int i = 0; i < 16; i++) if (f[i] <= v) e.n = i;
        e.exact = (f[e.n] == v) ? 1 : 0;
        e.blen = e.n + 1;
        return e;
    endfunction

    // Monitor
    int bcnt = 0;
    always @(negedge clk) begin : mon
        exp_t e;
        if (busy) bcnt++;
        if (valid) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got o_n=%0d, expected no pulse", n);
            end else begin
                e = q.pop_front();
                chk("o_n", int'(n), e.n);
                chk("o_exact", int'(exact), e.exact);
                chk("busy_len", bcnt, e.blen);
            end
            bcnt = 0;
        end else if (!busy) begin
            bcnt = 0;
        end
    end

    task automatic wait_idle();
        int g = 0;
        while (busy && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL timeout_idle: got busy=1, expected 0");
        end
    endtask

    task automatic start(input int v, input bit push);
        @(negedge clk);
        wait_idle();
        stb = 1'b1;
        val = v[WIDTH-1:0];
        if (push) q.push_back(mk(v));
        @(negedge clk);
        stb = 1'b0;
        val = WIDTH'($urandom);
    endtask

    task automatic wait_done();
        int g = 0;
        while ((q.size() != 0 || busy) && g < 200) begin
            @(negedge clk);
            val = WIDTH'($urandom);
            g++;
        end
        if (q.size() != 0 || busy) begin
            tests++;
            fails++;
            $display("FAIL timeout_done: got %0d pending, expected 0", q.size());
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_valid"}, int'(valid), 0);
        chk({tag, "_n"}, int'(n), 0);
        chk({tag, "_exact"}, int'(exact), 0);
    endtask

    initial begin
        int g;
        rst = 1'b1;
        stb = 1'b1;
        val = 8'hFF;
        repeat (2) begin
            @(negedge clk);
            chk_zero("rst");
        end
        rst = 1'b0;
        stb = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk_zero("post_rst");
        end

        foreach (q[i]) ;
        start(0, 1);   wait_done();
        start(1, 1);   wait_done();
        start(2, 1);   wait_done();
        start(233, 1); wait_done();
        start(255, 1); wait_done();
        start(100, 1); wait_done();
        start(144, 1); wait_done();

        // Strobes while busy, including on the completing edge
        start(100, 1);
        stb = 1'b1;
        val = 8'd5;
        g = 0;
        while (!valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        stb = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("hold_n", int'(n), 11);
            chk("hold_busy", int'(busy), 0);
        end
        start(5, 1);
        wait_done();

        // Reset mid-search
        start(233, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk_zero("abort");
        end
        start(8, 1);
        wait_done();

        // Random values with gaps and i_value noise while busy
        for (int i = 0; i < 40; i++) begin
            start(int'($urandom_range(0, 255)), 1);
            wait_done();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Exhaustive sweep with strobe held high
        @(negedge clk);
        stb = 1'b1;
        for (int v = 0; v < 256; v++) begin
            val = v[WIDTH-1:0];
            q.push_back(mk(v));
            @(negedge clk);
            g = 0;
            while (busy && g < 40) begin
                @(negedge clk);
                g++;
            end
            if (busy) begin
                tests++;
                fails++;
                $display("FAIL sweep_timeout: got busy=1 at v=%0d, expected 0", v);
            end
        end
        stb = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
